// File: rtl/ram_banked.sv
// Single-port synchronous RAM built from 256x16 banks with a two-stage registered read path.
// Define RAM_CLEAR_EN to zero all banks after reset (busy high, requests blocked meanwhile).
module ram_banked #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [(WIDTH+15)/16-1:0]    req_lane_en,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [WIDTH-1:0]            req_din,
  output logic                        rsp_valid,
  output logic [WIDTH-1:0]            rsp_dout,
  output logic                        busy
);

  localparam int unsigned NLANES    = (WIDTH + 15) / 16;
  localparam int unsigned PAD_W     = NLANES * 16;
  localparam int unsigned SEL_WIDTH = (ADDR_WIDTH > 8) ? ADDR_WIDTH - 8 : 0;
  localparam int unsigned NSEL      = 1 << SEL_WIDTH;
  localparam int unsigned SEL_W     = (SEL_WIDTH > 0) ? SEL_WIDTH : 1;
  localparam int unsigned OFF_W     = (ADDR_WIDTH < 8) ? ADDR_WIDTH : 8;

  logic               accept;
  logic               rd_en;
  logic               clearing;
  logic [7:0]         clr_addr;
  logic [7:0]         offset;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_q;
  logic               rd_valid_q;
  logic [7:0]         wr_addr;
  logic [PAD_W-1:0]   din_pad;
  logic [PAD_W-1:0]   wr_data;
  logic [PAD_W-1:0]   mux_pad;
  logic [NSEL*PAD_W-1:0] bank_dout;

`ifdef RAM_CLEAR_EN
  typedef enum logic {StClear, StRun} state_e;

  state_e     state_q;
  logic [7:0] clr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else if (state_q == StClear) begin
      clr_cnt_q <= clr_cnt_q + 8'd1;
      if (clr_cnt_q == 8'hFF) begin
        state_q <= StRun;
      end
    end
  end

  assign clearing = (state_q == StClear);
  assign clr_addr = clr_cnt_q;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  assign busy      = clearing;
  assign req_ready = ~clearing;
  assign accept    = req_valid & req_ready;
  assign rd_en     = accept & ~req_we;

  always_comb begin
    offset             = '0;
    offset[OFF_W-1:0]  = req_addr[OFF_W-1:0];
    din_pad            = '0;
    din_pad[WIDTH-1:0] = req_din;
  end

  if (ADDR_WIDTH > 8) begin : g_sel
    assign sel = req_addr[ADDR_WIDTH-1:8];
  end else begin : g_nosel
    assign sel = '0;
  end

  // The clear engine takes over the shared write port of every bank at once.
  assign wr_addr = clearing ? clr_addr : offset;
  assign wr_data = clearing ? '0 : din_pad;

  for (genvar s = 0; s < NSEL; s++) begin : g_bank
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
      logic [15:0] mem [256];
      logic [15:0] dout_q;
      logic        we;

      assign we = clearing | (accept & req_we & req_lane_en[l] & (sel == SEL_W'(s)));

      always_ff @(posedge clk) begin
        if (we) begin
          mem[wr_addr] <= wr_data[l*16 +: 16];
        end
        if (rd_en) begin
          dout_q <= mem[offset];
        end
      end

      assign bank_dout[s*PAD_W + l*16 +: 16] = dout_q;
    end
  end

  // Bank select comes from the stage-1 register so it lines up with the BRAM output.
  always_comb begin
    mux_pad = '0;
    for (int s = 0; s < NSEL; s++) begin
      if (sel_q == SEL_W'(s)) begin
        mux_pad = bank_dout[s*PAD_W +: PAD_W];
      end
    end
  end

  if (PAD_W > WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^mux_pad[PAD_W-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      sel_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_dout   <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        sel_q <= sel;
      end
      rsp_valid <= rd_valid_q;
      if (rd_valid_q) begin
        rsp_dout <= mux_pad[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ram_banked.sv
// Scoreboarded random test of ram_banked (24-bit x 1024) plus a small 8-bit x 16 instance.
module tb_ram_banked;

  localparam int W  = 24;
  localparam int AW = 10;
  localparam int NL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [NL-1:0] req_lane_en = '0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_din = '0;
  logic          rsp_valid;
  logic [W-1:0]  rsp_dout;
  logic          busy;

  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       s_we = 1'b0;
  logic [0:0] s_lane_en = 1'b1;
  logic [3:0] s_addr = '0;
  logic [7:0] s_din = '0;
  logic       s_rsp_valid;
  logic [7:0] s_rsp_dout;
  logic       s_busy;

  ram_banked #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_lane_en (req_lane_en),
    .req_addr    (req_addr),
    .req_din     (req_din),
    .rsp_valid   (rsp_valid),
    .rsp_dout    (rsp_dout),
    .busy        (busy)
  );

  ram_banked #(.WIDTH(8), .ADDR_WIDTH(4)) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (s_valid),
    .req_ready   (s_ready),
    .req_we      (s_we),
    .req_lane_en (s_lane_en),
    .req_addr    (s_addr),
    .req_din     (s_din),
    .rsp_valid   (s_rsp_valid),
    .rsp_dout    (s_rsp_dout),
    .busy        (s_busy)
  );

  int    checks = 0;
  int    errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] model [1 << AW];

  typedef struct {
    logic [W-1:0] data;
    longint       due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane_mask(input logic [NL-1:0] le);
    logic [W-1:0] m;
    m = '0;
    if (le[0]) m = m | 24'h00FFFF;
    if (le[1]) m = m | 24'hFF0000;
    return m;
  endfunction

  // Monitor: every response must match the oldest outstanding read, two edges after issue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rsp: got rsp_valid=1 data %0h, expected no response", rsp_dout);
      end else begin
        e = sb.pop_front();
        check("rsp_data", 64'(rsp_dout), 64'(e.data));
        check("rsp_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // All tasks start just after a falling edge and return at the next one.
  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NL-1:0] le);
    logic [W-1:0] m;
    m = lane_mask(le);
    model[a] = (model[a] & ~m) | (d & m);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_din = d; req_lane_en = le;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rd_issue(input logic [AW-1:0] a);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_din = W'($urandom); req_lane_en = 2'b11;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rd_exp(input logic [AW-1:0] a, input logic [W-1:0] exp);
    exp_t e;
    e.data = exp;
    e.due  = cyc + 2;
    sb.push_back(e);
    rd_issue(a);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_exp(a, model[a]);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] last_a;
    int            busy_bad;
    int            r;

    for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_dout", 64'(rsp_dout), 64'd0);
`ifdef RAM_CLEAR_EN
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_ready", 64'(req_ready), 64'd0);
    // Hold a read request through the clear walk; it must not be accepted.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h2A5;
    rst_n = 1'b1;
    busy_bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (busy !== 1'b1 || req_ready !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("clear_busy_cycles", 64'(busy_bad), 64'd0);
    check("clear_done_busy", 64'(busy), 64'd0);
    check("clear_done_ready", 64'(req_ready), 64'd1);
    rd_exp(10'h2A5, '0);
    rd_exp(10'h000, '0);
    rd_exp(10'h3FF, '0);
`else
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    wait_ready();

    for (int a = 0; a < (1 << AW); a++) wr(AW'(a), W'($urandom), 2'b11);

    // Read right after write, partial-lane write, then reads across bank boundaries.
    wr(10'h000, 24'h123456, 2'b11);
    rd_exp(10'h000, 24'h123456);
    wr(10'h1FF, 24'hAAAAAA, 2'b11);
    wr(10'h1FF, 24'h55BBBB, 2'b01);
    rd_exp(10'h1FF, 24'hAABBBB);
    wr(10'h0FF, 24'h111111, 2'b11);
    wr(10'h100, 24'h222222, 2'b11);
    wr(10'h2FF, 24'h333333, 2'b11);
    wr(10'h3FF, 24'h444444, 2'b11);
    rd_exp(10'h0FF, 24'h111111);
    rd_exp(10'h100, 24'h222222);
    rd_exp(10'h2FF, 24'h333333);
    rd_exp(10'h3FF, 24'h444444);
    wr(10'h2FF, 24'h0F0F0F, 2'b10);
    rd_exp(10'h2FF, 24'h0F3333);
    repeat (4) idle();

    last_a = '0;
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? last_a : AW'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0) idle();
      else if (r <= 3) wr(a, W'($urandom), NL'($urandom));
      else rd(a);
      last_a = a;
    end

    repeat (5) idle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset while a read is in flight: the response must be dropped.
    wr(10'h005, 24'hC0FFEE, 2'b11);
    rd_exp(10'h005, 24'hC0FFEE);
    repeat (3) idle();
    check("pre_reset_dout", 64'(rsp_dout), 64'hC0FFEE);
    rd_issue(10'h005);
    rst_n = 1'b0;
    #1;
    check("rst_drop_valid", 64'(rsp_valid), 64'd0);
    check("rst_drop_dout", 64'(rsp_dout), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_valid", 64'(rsp_valid), 64'd0);
      check("post_rst_dout", 64'(rsp_dout), 64'd0);
    end
    wait_ready();
    check("sb_empty_after_rst", 64'(sb.size()), 64'd0);

    // Small instance: one lane, one bank, 4-bit address.
    check("small_ready", 64'(s_ready), 64'd1);
    check("small_busy", 64'(s_busy), 64'd0);
    s_valid = 1'b1; s_we = 1'b1; s_addr = 4'hF; s_din = 8'h7F;
    @(negedge clk);
    s_addr = 4'h0; s_din = 8'h80;
    @(negedge clk);
    s_we = 1'b0; s_addr = 4'hF;
    @(negedge clk);
    s_addr = 4'h0;
    @(negedge clk);
    s_valid = 1'b0;
    check("small_rsp0_valid", 64'(s_rsp_valid), 64'd1);
    check("small_rsp0_data", 64'(s_rsp_dout), 64'h7F);
    @(negedge clk);
    check("small_rsp1_valid", 64'(s_rsp_valid), 64'd1);
    check("small_rsp1_data", 64'(s_rsp_dout), 64'h80);
    @(negedge clk);
    check("small_rsp_end", 64'(s_rsp_valid), 64'd0);
    check("small_dout_hold", 64'(s_rsp_dout), 64'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
